// File: rtl/voice_op_register_sequencer_pkg.sv
// Shared definitions for the register-write sequencer: register-number field layout,
// voice-op parameter indices, slot width derivation and the buffered write tag.
package voice_op_register_sequencer_pkg;

    localparam int REG_VALID_BIT  = 15;
    localparam int REG_GLOBAL_BIT = 14;
    localparam int REG_PARAM_MSB  = 13;
    localparam int REG_PARAM_LSB  = 8;
    localparam int REG_ADDR_W     = 14;
    localparam int PARAM_W        = REG_PARAM_MSB - REG_PARAM_LSB + 1;

    localparam logic [PARAM_W-1:0] PARAM_PHASE_STEP   = 6'h00;
    localparam logic [PARAM_W-1:0] PARAM_ALGORITHM    = 6'h01;
    localparam logic [PARAM_W-1:0] PARAM_ENV_ATTACK   = 6'h02;
    localparam logic [PARAM_W-1:0] PARAM_ENV_DECAY    = 6'h03;
    localparam logic [PARAM_W-1:0] PARAM_ENV_SUSTAIN  = 6'h04;
    localparam logic [PARAM_W-1:0] PARAM_ENV_RELEASE  = 6'h05;
    localparam logic [PARAM_W-1:0] PARAM_ENV_LEVEL    = 6'h06;
    localparam logic [PARAM_W-1:0] PARAM_FEEDBACK     = 6'h07;
    localparam logic [PARAM_W-1:0] PARAM_NOTE_ON_LO   = 6'h10;
    localparam logic [PARAM_W-1:0] PARAM_NOTE_ON_HI   = 6'h11;
    localparam logic [PARAM_W-1:0] PARAM_LED          = 6'h12;

    function automatic int voWidth(input int numVoices, input int numOperators);
        return $clog2(numVoices) + $clog2(numOperators);
    endfunction

    // For voice-op writes addr holds {param, slot}; for global writes it is the table index.
    typedef struct packed {
        logic                  isGlobal;
        logic [REG_ADDR_W-1:0] addr;
    } fifo_tag_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } dispatch_state_t;

endpackage

// File: rtl/voice_op_register_sequencer_sync_fifo.sv
// Small first-word-fall-through FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_PushData,
    input  logic             i_Pop,
    output logic [WIDTH-1:0] o_PopData,
    output logic             o_Full,
    output logic             o_Empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_Mem [DEPTH];
    logic [AW:0]      r_WrPtr;
    logic [AW:0]      r_RdPtr;
    logic             w_DoPush;
    logic             w_DoPop;

    assign o_Empty  = (r_WrPtr == r_RdPtr);
    assign o_Full   = (r_WrPtr[AW] != r_RdPtr[AW]) && (r_WrPtr[AW-1:0] == r_RdPtr[AW-1:0]);
    assign w_DoPop  = i_Pop & ~o_Empty;
    assign w_DoPush = i_Push & (~o_Full | w_DoPop);

    assign o_PopData = r_Mem[r_RdPtr[AW-1:0]];

    always_ff @(posedge i_Clock) begin
        if (w_DoPush) begin
            r_Mem[r_WrPtr[AW-1:0]] <= i_PushData;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
        end else begin
            if (w_DoPush) begin
                r_WrPtr <= r_WrPtr + 1'b1;
            end
            if (w_DoPop) begin
                r_RdPtr <= r_RdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_op_register_sequencer.sv
// Decodes edge-detected SPI register writes, buffers them and dispatches them as
// one-cycle strobes, optionally only at frame start; also owns the voice-op slot counter.
module voice_op_register_sequencer
    import voice_op_register_sequencer_pkg::*;
#(
    parameter int NUM_VOICES    = 32,
    parameter int NUM_OPERATORS = 8,
    parameter int NUM_PARAMS    = 20,
    parameter int DATA_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int SYNC_WRITES   = 1,
    localparam int VO_W         = voWidth(NUM_VOICES, NUM_OPERATORS)
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_RegisterWriteEnable,
    input  logic [15:0]           i_RegisterWriteNumber,
    input  logic [DATA_WIDTH-1:0] i_RegisterWriteValue,
    input  logic                  i_ClearOverflow,
    output logic [VO_W-1:0]       o_VoiceOperator,
    output logic                  o_FrameStart,
    output logic [NUM_PARAMS-1:0] o_ParamWriteEnable,
    output logic                  o_GlobalWriteEnable,
    output logic [13:0]           o_GlobalWriteAddress,
    output logic [VO_W-1:0]       o_ConfigWriteAddr,
    output logic [DATA_WIDTH-1:0] o_ConfigWriteData,
    output logic                  o_Busy,
    output logic                  o_Dropped,
    output logic                  o_Overflow
);

    localparam int                  ENTRY_W       = $bits(fifo_tag_t) + DATA_WIDTH;
    localparam logic [7:0]          VO_HIGH_MASK  = 8'hFF << VO_W;
    localparam logic [PARAM_W:0]    NUM_PARAMS_W  = (PARAM_W + 1)'(NUM_PARAMS);
    localparam logic [NUM_PARAMS-1:0] PARAM_ONE   = NUM_PARAMS'(1);

    logic                  r_WeLast;
    logic [VO_W-1:0]       r_Slot;
    dispatch_state_t       r_State;
    dispatch_state_t       w_NextState;

    logic                  w_Accept;
    logic                  w_IsValid;
    logic                  w_PushReq;
    logic                  w_Push;
    logic                  w_Pop;
    logic                  w_Lost;
    logic                  w_DropNow;
    logic                  w_Full;
    logic                  w_Empty;
    fifo_tag_t             w_InTag;
    fifo_tag_t             w_OutTag;
    logic [DATA_WIDTH-1:0] w_OutValue;
    logic [ENTRY_W-1:0]    w_FifoOut;

    logic [NUM_PARAMS-1:0] r_ParamWriteEnable;
    logic                  r_GlobalWriteEnable;
    logic [13:0]           r_GlobalWriteAddress;
    logic [VO_W-1:0]       r_ConfigWriteAddr;
    logic [DATA_WIDTH-1:0] r_ConfigWriteData;
    logic                  r_Dropped;
    logic                  r_Overflow;

    assign w_Accept = i_RegisterWriteEnable & ~r_WeLast;

    // Voice-op writes must fit the slot field and name an existing parameter strobe.
    always_comb begin
        w_IsValid = i_RegisterWriteNumber[REG_VALID_BIT];
        if (!i_RegisterWriteNumber[REG_GLOBAL_BIT]) begin
            if ((i_RegisterWriteNumber[7:0] & VO_HIGH_MASK) != 8'h00) begin
                w_IsValid = 1'b0;
            end
            if ({1'b0, i_RegisterWriteNumber[REG_PARAM_MSB:REG_PARAM_LSB]} >= NUM_PARAMS_W) begin
                w_IsValid = 1'b0;
            end
        end
    end

    always_comb begin
        w_InTag          = '0;
        w_InTag.isGlobal = i_RegisterWriteNumber[REG_GLOBAL_BIT];
        w_InTag.addr     = i_RegisterWriteNumber[REG_ADDR_W-1:0];
    end

    assign w_PushReq = w_Accept & w_IsValid;
    assign w_Push    = w_PushReq & (~w_Full | w_Pop);
    assign w_Lost    = w_PushReq & w_Full & ~w_Pop;
    assign w_DropNow = (w_Accept & ~w_IsValid) | w_Lost;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock    (i_Clock),
        .i_Reset_n  (i_Reset_n),
        .i_Push     (w_Push),
        .i_PushData ({w_InTag, i_RegisterWriteValue}),
        .i_Pop      (w_Pop),
        .o_PopData  (w_FifoOut),
        .o_Full     (w_Full),
        .o_Empty    (w_Empty)
    );

    assign {w_OutTag, w_OutValue} = w_FifoOut;

    // In synchronous mode a burst only starts on slot 0 and keeps going while entries remain.
    always_comb begin
        w_NextState = r_State;
        w_Pop       = 1'b0;
        if (SYNC_WRITES == 0) begin
            w_Pop       = ~w_Empty;
            w_NextState = ST_IDLE;
        end else begin
            case (r_State)
                ST_IDLE: begin
                    if ((r_Slot == '0) && !w_Empty) begin
                        w_Pop       = 1'b1;
                        w_NextState = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_Empty) begin
                        w_Pop = 1'b1;
                    end else if (!w_PushReq) begin
                        w_NextState = ST_IDLE;
                    end
                end
                default: w_NextState = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_WeLast <= 1'b0;
            r_Slot   <= '0;
            r_State  <= ST_IDLE;
        end else begin
            r_WeLast <= i_RegisterWriteEnable;
            r_Slot   <= r_Slot + 1'b1;
            r_State  <= w_NextState;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_ParamWriteEnable   <= '0;
            r_GlobalWriteEnable  <= 1'b0;
            r_GlobalWriteAddress <= '0;
            r_ConfigWriteAddr    <= '0;
            r_ConfigWriteData    <= '0;
            r_Dropped            <= 1'b0;
            r_Overflow           <= 1'b0;
        end else begin
            r_ParamWriteEnable  <= '0;
            r_GlobalWriteEnable <= 1'b0;
            r_Dropped           <= w_DropNow;
            if (w_Pop) begin
                r_ConfigWriteData <= w_OutValue;
                if (w_OutTag.isGlobal) begin
                    r_GlobalWriteEnable  <= 1'b1;
                    r_GlobalWriteAddress <= w_OutTag.addr;
                end else begin
                    r_ParamWriteEnable <= PARAM_ONE << w_OutTag.addr[REG_PARAM_MSB:REG_PARAM_LSB];
                    r_ConfigWriteAddr  <= w_OutTag.addr[VO_W-1:0];
                end
            end
            if (w_Lost) begin
                r_Overflow <= 1'b1;
            end else if (i_ClearOverflow) begin
                r_Overflow <= 1'b0;
            end
        end
    end

    assign o_VoiceOperator      = r_Slot;
    assign o_FrameStart         = (r_Slot == '0);
    assign o_ParamWriteEnable   = r_ParamWriteEnable;
    assign o_GlobalWriteEnable  = r_GlobalWriteEnable;
    assign o_GlobalWriteAddress = r_GlobalWriteAddress;
    assign o_ConfigWriteAddr    = r_ConfigWriteAddr;
    assign o_ConfigWriteData    = r_ConfigWriteData;
    assign o_Busy               = ~w_Empty | (r_State == ST_DRAIN);
    assign o_Dropped            = r_Dropped;
    assign o_Overflow           = r_Overflow;

endmodule

// File: tb/tb_voice_op_register_sequencer.sv
// Bench for the register-write sequencer: an immediate-dispatch and a frame-synchronous
// instance share one stimulus stream and are both checked against a queue-based model.
module tb_voice_op_register_sequencer;

    localparam int TB_VOW    = 8;
    localparam int TB_PARAMS = 20;
    localparam int TB_DEPTH  = 4;
    localparam int TB_SLOTS  = 256;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        we    = 1'b0;
    logic        clr   = 1'b0;
    logic [15:0] num   = 16'h0000;
    logic [15:0] val   = 16'h0000;

    logic [7:0]  vo   [2];
    logic        fs   [2];
    logic [19:0] pwe  [2];
    logic        gwe  [2];
    logic [13:0] ga   [2];
    logic [7:0]  ca   [2];
    logic [15:0] cd   [2];
    logic        busy [2];
    logic        drop [2];
    logic        ovf  [2];

    int checks = 0;
    int passes = 0;
    int strobeCnt [2] = '{0, 0};
    int dropCnt   [2] = '{0, 0};
    int fsCnt, snapS0, snapS1, snapD0, snapD1;

    always #5 clk = ~clk;

    voice_op_register_sequencer #(
        .NUM_VOICES(32), .NUM_OPERATORS(8), .NUM_PARAMS(TB_PARAMS),
        .DATA_WIDTH(16), .FIFO_DEPTH(TB_DEPTH), .SYNC_WRITES(0)
    ) dut0 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_RegisterWriteEnable(we),
        .i_RegisterWriteNumber(num), .i_RegisterWriteValue(val), .i_ClearOverflow(clr),
        .o_VoiceOperator(vo[0]), .o_FrameStart(fs[0]), .o_ParamWriteEnable(pwe[0]),
        .o_GlobalWriteEnable(gwe[0]), .o_GlobalWriteAddress(ga[0]), .o_ConfigWriteAddr(ca[0]),
        .o_ConfigWriteData(cd[0]), .o_Busy(busy[0]), .o_Dropped(drop[0]), .o_Overflow(ovf[0])
    );

    voice_op_register_sequencer #(
        .NUM_VOICES(32), .NUM_OPERATORS(8), .NUM_PARAMS(TB_PARAMS),
        .DATA_WIDTH(16), .FIFO_DEPTH(TB_DEPTH), .SYNC_WRITES(1)
    ) dut1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_RegisterWriteEnable(we),
        .i_RegisterWriteNumber(num), .i_RegisterWriteValue(val), .i_ClearOverflow(clr),
        .o_VoiceOperator(vo[1]), .o_FrameStart(fs[1]), .o_ParamWriteEnable(pwe[1]),
        .o_GlobalWriteEnable(gwe[1]), .o_GlobalWriteAddress(ga[1]), .o_ConfigWriteAddr(ca[1]),
        .o_ConfigWriteData(cd[1]), .o_Busy(busy[1]), .o_Dropped(drop[1]), .o_Overflow(ovf[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a pending-write queue per instance; instance 1 only starts emptying it on slot 0.
    typedef struct packed {
        logic        isGlobal;
        logic [13:0] addr;
        logic [15:0] value;
    } mEntry_t;

    mEntry_t     mQueue [2][$];
    bit          mDrain;
    bit          mWeLast;
    int          mSlot;
    logic [19:0] eParam   [2];
    logic        eGlobal  [2];
    logic [13:0] eGaddr   [2];
    logic [7:0]  eCaddr   [2];
    logic [15:0] eData    [2];
    logic        eDropped [2];
    logic        eOvf     [2];
    logic        eBusy    [2];

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mQueue[k].delete();
            eParam[k]   = '0;
            eGlobal[k]  = 1'b0;
            eGaddr[k]   = '0;
            eCaddr[k]   = '0;
            eData[k]    = '0;
            eDropped[k] = 1'b0;
            eOvf[k]     = 1'b0;
            eBusy[k]    = 1'b0;
        end
        mDrain  = 1'b0;
        mWeLast = 1'b0;
        mSlot   = 0;
    endtask

    task automatic modelStep();
        bit accepted, legal, pop, pushed, lost;
        mEntry_t e;
        accepted = we && !mWeLast;
        mWeLast  = we;
        legal    = num[15];
        if (!num[14]) begin
            if (int'(num[13:8]) >= TB_PARAMS) legal = 1'b0;
            if ((int'(num[7:0]) >> TB_VOW) != 0) legal = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 1 && !mDrain) pop = (mSlot == 0) && (mQueue[k].size() > 0);
            else                   pop = (mQueue[k].size() > 0);
            eParam[k]   = '0;
            eGlobal[k]  = 1'b0;
            eDropped[k] = 1'b0;
            pushed      = 1'b0;
            lost        = 1'b0;
            if (pop) begin
                e        = mQueue[k].pop_front();
                eData[k] = e.value;
                if (e.isGlobal) begin
                    eGlobal[k] = 1'b1;
                    eGaddr[k]  = e.addr;
                end else begin
                    eParam[k] = 20'd1 << e.addr[13:8];
                    eCaddr[k] = e.addr[7:0];
                end
            end
            if (accepted) begin
                if (!legal) begin
                    eDropped[k] = 1'b1;
                end else if (mQueue[k].size() >= TB_DEPTH) begin
                    eDropped[k] = 1'b1;
                    lost        = 1'b1;
                end else begin
                    mQueue[k].push_back({num[14], num[13:0], val});
                    pushed = 1'b1;
                end
            end
            if (lost)     eOvf[k] = 1'b1;
            else if (clr) eOvf[k] = 1'b0;
            if (k == 1) begin
                if (!mDrain && pop)                    mDrain = 1'b1;
                else if (mDrain && !pop && !pushed)    mDrain = 1'b0;
            end
            eBusy[k] = (mQueue[k].size() > 0) || (k == 1 && mDrain);
        end
        mSlot = (mSlot + 1) % TB_SLOTS;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelReset();
        else        modelStep();
    end

    // Every active cycle both instances are compared against the model.
    always @(posedge clk) begin
        #2;
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("dut%0d.slot", k),       vo[k],   mSlot[7:0]);
                checkOutput($sformatf("dut%0d.frameStart", k), fs[k],   (mSlot == 0));
                checkOutput($sformatf("dut%0d.paramWe", k),    pwe[k],  eParam[k]);
                checkOutput($sformatf("dut%0d.globalWe", k),   gwe[k],  eGlobal[k]);
                checkOutput($sformatf("dut%0d.globalAddr", k), ga[k],   eGaddr[k]);
                checkOutput($sformatf("dut%0d.configAddr", k), ca[k],   eCaddr[k]);
                checkOutput($sformatf("dut%0d.configData", k), cd[k],   eData[k]);
                checkOutput($sformatf("dut%0d.busy", k),       busy[k], eBusy[k]);
                checkOutput($sformatf("dut%0d.dropped", k),    drop[k], eDropped[k]);
                checkOutput($sformatf("dut%0d.overflow", k),   ovf[k],  eOvf[k]);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                strobeCnt[k] += $countones(pwe[k]) + int'(gwe[k]);
                dropCnt[k]   += int'(drop[k]);
            end
        end
    end

    task automatic applyStimulus(input bit en, input logic [15:0] n, input logic [15:0] v, input bit c);
        we  = en;
        num = n;
        val = v;
        clr = c;
    endtask

    task automatic pulseWrite(input logic [15:0] n, input logic [15:0] v);
        applyStimulus(1'b1, n, v, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, n, v, 1'b0);
        @(negedge clk);
    endtask

    task automatic waitSlot(input int k, input int target, input int budget);
        int i = 0;
        while (vo[k] !== 8'(target) && i < budget) begin
            @(negedge clk);
            i++;
        end
        checkOutput("waitSlot", vo[k], target);
    endtask

    task automatic waitIdle(input int k, input int budget);
        int i = 0;
        while (busy[k] !== 1'b0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        checkOutput("waitIdle", busy[k], 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired: checks=%0d passed=%0d", checks, passes);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and a full idle frame plus some: count slot-0 cycles.
        checkOutput("resetSlot",     vo[0],   0);
        checkOutput("resetFrame",    fs[0],   1);
        checkOutput("resetParamWe",  pwe[1],  0);
        checkOutput("resetOverflow", ovf[1],  0);
        checkOutput("resetBusy",     busy[1], 0);
        fsCnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (fs[0]) fsCnt++;
            if (i == 255) checkOutput("slotBeforeWrap", vo[0], 255);
            if (i == 256) checkOutput("slotAfterWrap",  vo[0], 0);
            @(negedge clk);
        end
        checkOutput("frameStartCount", fsCnt, 2);
        checkOutput("idleStrobes", strobeCnt[0] + strobeCnt[1], 0);

        // Level enable held for 10 cycles: one strobe, two cycles after the rise.
        snapS0 = strobeCnt[0];
        applyStimulus(1'b1, 16'h8205, 16'h1234, 1'b0);
        @(negedge clk);
        checkOutput("latencyNotYet", pwe[0], 0);
        @(negedge clk);
        checkOutput("latencyStrobe", pwe[0], 20'h00004);
        checkOutput("latencyAddr",   ca[0],  8'h05);
        checkOutput("latencyData",   cd[0],  16'h1234);
        repeat (8) @(negedge clk);
        applyStimulus(1'b0, 16'h8205, 16'h1234, 1'b0);
        @(negedge clk);
        checkOutput("singleStrobe", strobeCnt[0] - snapS0, 1);

        // Global then voice-op write keeps order.
        applyStimulus(1'b1, 16'hC010, 16'h7FFF, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'hC010, 16'h7FFF, 1'b0);
        @(negedge clk);
        checkOutput("orderGlobalWe",   gwe[0], 1);
        checkOutput("orderGlobalAddr", ga[0],  14'h0010);
        checkOutput("orderGlobalData", cd[0],  16'h7FFF);
        checkOutput("orderNoParamYet", pwe[0], 0);
        applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h8000, 16'h0001, 1'b0);
        @(negedge clk);
        checkOutput("orderParamWe",   pwe[0], 20'h00001);
        checkOutput("orderParamAddr", ca[0],  0);
        checkOutput("orderParamData", cd[0],  16'h0001);

        // Frame-synchronous dispatch: writes at slot 40 wait for the wrap.
        waitIdle(1, 600);
        waitSlot(1, 40, 300);
        snapS1 = strobeCnt[1];
        for (int i = 0; i < 3; i++) pulseWrite(16'h8100 | 16'(i), 16'h00A0 + 16'(i));
        waitSlot(1, 0, 300);
        checkOutput("syncNoEarlyStrobe", strobeCnt[1] - snapS1, 0);
        checkOutput("syncBusyWaiting",   busy[1], 1);
        @(negedge clk);
        checkOutput("syncSlot1Strobe", pwe[1], 20'h00002);
        checkOutput("syncSlot1Data",   cd[1],  16'h00A0);
        @(negedge clk);
        checkOutput("syncSlot2Addr",   ca[1],  8'h01);
        checkOutput("syncSlot2Data",   cd[1],  16'h00A1);
        @(negedge clk);
        checkOutput("syncSlot3Data",   cd[1],  16'h00A2);
        checkOutput("syncSlot3Busy",   busy[1], 1);
        @(negedge clk);
        checkOutput("syncSlot4Busy",   busy[1], 0);
        checkOutput("syncSlot4NoStrobe", pwe[1], 0);

        // Six writes into a four-entry buffer within one frame.
        waitIdle(1, 600);
        waitSlot(1, 10, 300);
        snapS0 = strobeCnt[0];
        snapS1 = strobeCnt[1];
        snapD0 = dropCnt[0];
        snapD1 = dropCnt[1];
        for (int i = 0; i < 6; i++) pulseWrite(16'h8300 | 16'(i), 16'h0100 + 16'(i));
        checkOutput("ovfDropped",      dropCnt[1] - snapD1, 2);
        checkOutput("ovfSet",          ovf[1], 1);
        checkOutput("ovfHeldBack",     strobeCnt[1] - snapS1, 0);
        checkOutput("ovfImmediateAll", strobeCnt[0] - snapS0, 6);
        checkOutput("ovfImmediateNoDrop", dropCnt[0] - snapD0, 0);
        applyStimulus(1'b1, 16'h0000, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        checkOutput("ovfCleared", ovf[1], 0);
        waitSlot(1, 0, 300);
        repeat (6) @(negedge clk);
        checkOutput("ovfDispatched", strobeCnt[1] - snapS1, 4);

        // Illegal register numbers are dropped without touching overflow.
        snapS0 = strobeCnt[0];
        snapD0 = dropCnt[0];
        pulseWrite(16'h0205, 16'h1111);
        pulseWrite(16'h9400, 16'h2222);
        repeat (3) @(negedge clk);
        checkOutput("invalidDropped",  dropCnt[0] - snapD0, 2);
        checkOutput("invalidNoStrobe", strobeCnt[0] - snapS0, 0);
        checkOutput("invalidNoOvf",    ovf[0], 0);

        // Reset in the middle of a drain burst.
        waitIdle(1, 600);
        waitSlot(1, 50, 300);
        for (int i = 0; i < 3; i++) pulseWrite(16'h8400 | 16'(i), 16'h0300 + 16'(i));
        waitSlot(1, 1, 300);
        checkOutput("drainFirstStrobe", pwe[1], 20'h00010);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetSlot",   vo[1],   0);
        checkOutput("midResetFrame",  fs[1],   1);
        checkOutput("midResetParam",  pwe[1],  0);
        checkOutput("midResetGlobal", gwe[1],  0);
        checkOutput("midResetGaddr",  ga[1],   0);
        checkOutput("midResetCaddr",  ca[1],   0);
        checkOutput("midResetData",   cd[1],   0);
        checkOutput("midResetBusy",   busy[1], 0);
        checkOutput("midResetDrop",   drop[1], 0);
        checkOutput("midResetOvf",    ovf[1],  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snapS1 = strobeCnt[1];
        repeat (20) @(negedge clk);
        checkOutput("postResetNoStrobe", strobeCnt[1] - snapS1, 0);
        checkOutput("postResetIdle",     busy[1], 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/voice_op_register_sequencer.md
Name: voice_op_register_sequencer

Overview:
Parametrised successor to the top-level register-write decode and voice-operator slot counter. It edge-detects SPI register writes and decodes them into per-parameter write strobes or global (sine-table) writes. Writes are buffered in a small FIFO. Each write is dispatched either immediately or deferred to a frame boundary, so that a voice-operator update never lands part-way through a frame. The block also owns the time-multiplexed voice-operator slot counter that feeds the stage pipeline.

Parameters:
NUM_VOICES, 32, voices per frame; power of 2, 2..32
NUM_OPERATORS, 8, operators per voice; power of 2, 2..8
NUM_PARAMS, 20, number of voice-op parameter strobes; 1..64
DATA_WIDTH, 16, register value width
FIFO_DEPTH, 4, pending-write buffer entries; power of 2, >=2
SYNC_WRITES, 1, 0 = dispatch as soon as buffered; 1 = dispatch only in a drain burst starting at frame start

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  asynchronous, active-low reset
i_RegisterWriteEnable  in  1  level write-enable from SPI; may stay high for many cycles
i_RegisterWriteNumber  in  16  register number
i_RegisterWriteValue  in  DATA_WIDTH  register value
i_ClearOverflow  in  1  clears o_Overflow
o_VoiceOperator  out  VO_W  current slot {operator, voice}; VO_W = log2(NUM_VOICES) + log2(NUM_OPERATORS)
o_FrameStart  out  1  high while o_VoiceOperator == 0
o_ParamWriteEnable  out  NUM_PARAMS  one-hot, one-cycle voice-op write strobe
o_GlobalWriteEnable  out  1  one-cycle global write strobe
o_GlobalWriteAddress  out  14  global register index
o_ConfigWriteAddr  out  VO_W  target voice-operator
o_ConfigWriteData  out  DATA_WIDTH  write value
o_Busy  out  1  FIFO not empty, or drain state active
o_Dropped  out  1  one-cycle pulse when a write is rejected
o_Overflow  out  1  sticky; set when a write is lost to a full FIFO

Behaviour:
- Reset: asynchronous on i_Reset_n low. Slot counter = 0; FIFO empty; state IDLE; edge register = 0; all strobes, o_Dropped and o_Overflow = 0; address/data outputs = 0.
- Edge detect: r_WeLast <= i_RegisterWriteEnable. A write is accepted only in a cycle where enable = 1 and r_WeLast = 0.
  - If enable is already high when reset deasserts, that counts as an edge.
- Decode, in the accept cycle:
  - bit15 must be 1, otherwise drop.
  - bit14 = 1 -> global write; address = bits[13:0].
  - bit14 = 0 -> voice-op write; param = bits[13:8], VO address = bits[VO_W-1:0].
  - Voice-op drop conditions: bits[7:VO_W] nonzero, or param >= NUM_PARAMS.
  - A dropped write pulses o_Dropped the next cycle and is not buffered.
- FIFO entry = {isGlobal, param/addr, value}.
  - Push and pop in the same cycle are allowed even when full.
  - Push when full with no pop: write discarded, o_Dropped pulses, o_Overflow set.
  - i_ClearOverflow clears o_Overflow; a set in the same cycle wins.
- Slot counter: increments every cycle and wraps naturally at NUM_VOICES*NUM_OPERATORS. The operator index is the MSB field. o_FrameStart is combinational from the counter.
- Dispatch when SYNC_WRITES = 0: pop whenever the FIFO is non-empty, one entry per cycle.
- Dispatch when SYNC_WRITES = 1: two-state FSM.
  - IDLE -> DRAIN when the counter == 0 and the FIFO is non-empty; pop in that cycle.
  - DRAIN: pop one entry per cycle, including entries pushed during the burst.
  - DRAIN -> IDLE in the cycle after the final pop (FIFO empty, no push).
- Output register: a popped entry drives exactly one strobe for exactly one cycle, registered, so it appears the cycle after the pop. Address/data update with the strobe and hold until the next strobe.
- Latency with SYNC_WRITES = 0 and an empty FIFO: first enable-high cycle N -> pushed at the end of N -> popped in N+1 -> strobe in N+2.
- Write order to the outputs equals SPI accept order. Global and voice-op writes share one queue.
- Reset asserted mid-drain or mid-write: everything pending is discarded; no strobe follows reset.

Decomposition:
- synth_pkg holds:
  - register-number field positions (bit15 valid, bit14 global, [13:8] param);
  - parameter index constants (PHASE_STEP = 0, ALGORITHM = 1, ENV_* = 2..6, FEEDBACK = 7, NOTE_ON = 0x10/0x11, LED = 0x12);
  - VO_W derivation function;
  - FIFO entry struct typedef.
- One sub-module: sync_fifo.
  - Parametrised width and depth; async active-low reset.
  - Outputs full/empty; supports simultaneous push and pop.

Test Plan:
- Reset, then 300 idle cycles -> o_VoiceOperator counts 0..255 and wraps; o_FrameStart high exactly at cycles 0 and 256; no strobes.
- SYNC_WRITES = 0; enable held high 10 cycles with number 0x8205, value 0x1234 -> o_ParamWriteEnable[2] high for exactly one cycle, 2 cycles after the rise; ConfigWriteAddr = 0x05, data = 0x1234; no second strobe.
- Global write 0xC010 / 0x7FFF, then voice-op 0x8000 / 0x0001 -> o_GlobalWriteEnable (addr 0x0010) strobes before o_ParamWriteEnable[0], preserving order.
- SYNC_WRITES = 1; 3 writes issued at slot 40 -> no strobes until the counter wraps to 0; strobes at slots 1, 2, 3; o_Busy falls after the burst.
- FIFO_DEPTH = 4; SYNC_WRITES = 1; 6 writes in one frame -> 4 dispatched at the next frame, 2 dropped, o_Overflow = 1; i_ClearOverflow -> 0.
- Invalid numbers 0x0205 (bit15 = 0) and 0x9400 (param 20) -> o_Dropped pulses, no strobes, o_Overflow stays 0. Separately, reset asserted mid-drain -> no further strobes, all outputs at reset values.
